// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Consumed by pc_sequencer and sat_counter via import pc_seq_pkg::*.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_0100;
    localparam logic [31:0] PC_PLUS_4    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Used to count accepted fetch redirects.
module sat_counter
    import pc_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: hold / +4 / redirect, imem request and flush.
// Optional PC_ALIGN_CHECK_EN traps misaligned redirect targets to EXC_PC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             halt,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic             if_valid,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             misalign_err
);

    state_t      state;
    logic        fetching;
    logic        redirect;
    logic        advance;
    logic        tgt_misalign;
    logic [31:0] target_pc;
    logic [31:0] pc_next;

    assign fetching = (state == ST_FETCH);
    assign redirect = fetching & br_taken;
    assign advance  = fetching & ~br_taken & ~halt & ~stall & imem_ready;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt_misalign = (br_target[1:0] != 2'b00);
`else
    assign tgt_misalign = 1'b0;
`endif

    assign target_pc = tgt_misalign ? EXC_PC : word_align(br_target);

    assign pc4       = pc + PC_PLUS_4;
    assign imem_req  = fetching;
    assign imem_addr = pc;
    assign if_valid  = advance;
    assign flush     = redirect;

    always_comb begin
        pc_next = pc;
        unique case (1'b1)
            redirect: pc_next = target_pc;
            advance:  pc_next = pc4;
            default:  pc_next = pc;
        endcase
    end

    // HALT is terminal; only reset brings the fetch unit back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            pc <= pc_next;
            unique case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: begin
                    if (!br_taken && halt) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_BOOT;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect & tgt_misalign;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

    sat_counter #(
        .W(CNT_W)
    ) u_redirect_cnt (
        .clk(clk),
        .rst(rst),
        .inc(redirect),
        .cnt(redirect_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus
// randomized traffic against a behavioural fetch-unit model.
module tb_pc_sequencer;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic [31:0]   br_target = '0;
    logic          halt = 1'b0;
    logic          imem_ready = 1'b0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   pc;
    logic [31:0]   pc4;
    logic          if_valid;
    logic          flush;
    logic [CW-1:0] redirect_cnt;
    logic          misalign_err;

    int checks = 0;
    int errors = 0;

    // model: phase 0 = booting, 1 = running, 2 = halted
    int          phase;
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_merr;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC(32'h0),
        .EXC_PC(32'h100),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .halt(halt),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .pc(pc),
        .pc4(pc4),
        .if_valid(if_valid),
        .flush(flush),
        .redirect_cnt(redirect_cnt),
        .misalign_err(misalign_err)
    );

    task automatic model_reset();
        phase  = 0;
        m_pc   = 32'h0;
        m_cnt  = 0;
        m_merr = 1'b0;
    endtask

    task automatic model_edge();
        m_merr = 1'b0;
        if (phase == 0) begin
            phase = 1;
        end else if (phase == 1) begin
            if (br_taken) begin
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
                if (ALIGN && (br_target % 4) != 0) begin
                    m_pc   = 32'h100;
                    m_merr = 1'b1;
                end else begin
                    m_pc = br_target - (br_target % 4);
                end
            end else if (halt) begin
                phase = 2;
            end else if (!stall && imem_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic b, input logic h,
                       input logic r, input logic [31:0] t);
        stall      = s;
        br_taken   = b;
        halt       = h;
        imem_ready = r;
        br_target  = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 1, 0, 1, 32'h40);
        model_reset();
        checks++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h exp %h", pc, 32'h0);
        end
        checks++;
        if ({imem_req, if_valid, flush, misalign_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0000",
                     {imem_req, if_valid, flush, misalign_err});
        end
        checks++;
        if (redirect_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", redirect_cnt);
        end
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_req got %b%b exp 00", imem_req, if_valid);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0);
            checks++;
            if (pc !== 32'(4 * i) || if_valid !== 1'b1 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL seq_pc got %h/%b exp %h/1", pc, if_valid, 4 * i);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 1, 0);
            checks++;
            if (pc !== 32'h8 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got %h/%b exp 8/0", pc, if_valid);
            end
            tick();
        end
        cyc(0, 0, 0, 1, 0);
        tick();
        cyc(1, 1, 0, 1, 32'h40);
        checks++;
        if (pc !== 32'hC || flush !== 1'b1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_stall got %h/%b exp c/1", pc, flush);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (pc !== 32'h40 || imem_req !== 1'b1 || if_valid !== 1'b0
                || redirect_cnt !== CW'(1) || flush !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait got %h/%b/%b/%0d exp 40/1/0/1",
                         pc, imem_req, if_valid, redirect_cnt);
            end
            tick();
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_done got %b exp 1", if_valid);
        end
        tick();
        cyc(0, 0, 1, 1, 0);
        checks++;
        if (pc !== 32'h44 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_req got %h/%b exp 44/0", pc, if_valid);
        end
        tick();
        cyc(0, 1, 0, 1, 32'h80);
        checks++;
        if (imem_req !== 1'b0 || flush !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_br got %b%b%b exp 000", imem_req, flush, if_valid);
        end
        tick();
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (pc !== 32'h44 || redirect_cnt !== CW'(1) || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold got %h/%0d exp 44/1", pc, redirect_cnt);
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (pc !== 32'h0 || redirect_cnt !== '0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got %h/%0d exp 0/0", pc, redirect_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        exp_pc = ALIGN ? 32'h100 : 32'h40;
        do_reset();
        cyc(0, 0, 0, 1, 0);
        tick();
        cyc(0, 1, 0, 1, 32'h42);
        tick();
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (pc !== exp_pc || misalign_err !== ALIGN) begin
            errors++;
            $display("FAIL misalign got %h/%b exp %h/%b",
                     pc, misalign_err, exp_pc, ALIGN);
        end
        tick();
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse got %b exp 0", misalign_err);
        end
    endtask

    task automatic test_wrap();
        cyc(0, 1, 0, 0, 32'hFFFF_FFFC);
        tick();
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc4 got %h/%h exp fffffffc/0", pc, pc4);
        end
        tick();
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (pc !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc got %h exp 0", pc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < CMAX + 4; i++) begin
            cyc(1'($urandom), 1, 1'($urandom), 1'($urandom),
                $urandom & 32'hFFFF_FFFC);
            tick();
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (redirect_cnt !== CW'(i + 1 > CMAX ? CMAX : i + 1)) begin
                errors++;
                $display("FAIL sat_cnt got %0d exp %0d", redirect_cnt,
                         i + 1 > CMAX ? CMAX : i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic          e_req, e_valid, e_flush;
        logic [CW-1:0] e_cnt;
        logic [31:0]   t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (phase == 2 && $urandom_range(0, 4) == 0) do_reset();
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t = t & 32'hFFFF_FFFC;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, t);
            e_req   = (phase == 1);
            e_flush = (phase == 1) && br_taken;
            e_valid = (phase == 1) && !br_taken && !halt && !stall && imem_ready;
            e_cnt   = CW'(m_cnt);
            checks++;
            if ({pc, imem_addr, pc4, imem_req, if_valid, flush, redirect_cnt,
                 misalign_err} !== {m_pc, m_pc, m_pc + 32'd4, e_req, e_valid,
                 e_flush, e_cnt, m_merr}) begin
                errors++;
                $display("FAIL rand[%0d] got pc=%h pc4=%h req=%b v=%b fl=%b c=%0d me=%b exp pc=%h req=%b v=%b fl=%b c=%0d me=%b",
                         i, pc, pc4, imem_req, if_valid, flush, redirect_cnt,
                         misalign_err, m_pc, e_req, e_valid, e_flush, e_cnt, m_merr);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_misalign();
        test_wrap();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
